decrypt_message_checker: RTL

Scans the decrypted message RAM written by the RC4 decryption stage and decides whether the candidate secret key produced a plaintext message. It sits directly downstream of the KSA/decrypt datapath and feeds `Decrypt_Valid` / `Checker_Finish` to the `Get_Next_Secret_Key` FSM, which either stops or advances the key. A message is valid when every byte is lowercase `a`–`z` (0x61–0x7A) or space (0x20).

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/decrypt_message_checker_if.sv | 23 ++
 rtl/decrypt_message_checker.sv | 84 ++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 checker definitions: message constants, checker FSM states and
// the plaintext character classifier.
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;
  localparam logic [7:0] CHAR_LO_A  = 8'h61;
  localparam logic [7:0] CHAR_LO_Z  = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } checker_state_t;

  function automatic logic is_plaintext_char(input logic [7:0] b);
    return ((b >= CHAR_LO_A) && (b <= CHAR_LO_Z)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/decrypt_message_checker_if.sv
// Start/RAM-read/verdict bundle between the message checker (master) and
// the key-search FSM plus message RAM (slave).
interface decrypt_message_checker_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              busy;
  logic              Decrypt_Valid;
  logic              Checker_Finish;
  logic [ADDR_W-1:0] bad_index;

  modport master (
    input  start, rd_data,
    output rd_addr, busy, Decrypt_Valid, Checker_Finish, bad_index
  );

  modport slave (
    output start, rd_data,
    input  rd_addr, busy, Decrypt_Valid, Checker_Finish, bad_index
  );
endinterface

// File: rtl/decrypt_message_checker.sv
// Scans the decrypted message RAM and flags whether every byte is 'a'-'z' or space.
// Define CHECKER_EARLY_ABORT_EN to leave the scan on the first invalid byte.
module decrypt_message_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int ADDR_W  = 5
) (
  input logic                       clk,
  input logic                       reset_n,
  decrypt_message_checker_if.master bus
);

`ifdef CHECKER_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  checker_state_t    state;
  logic              chk_en;
  logic              fail;
  logic [ADDR_W-1:0] data_idx;
  logic              byte_bad;
  logic              accept;

  always_comb begin
    byte_bad = !is_plaintext_char(bus.rd_data);
    accept   = bus.start && (state != SCAN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      chk_en             <= 1'b0;
      fail               <= 1'b0;
      data_idx           <= '0;
      bus.rd_addr        <= '0;
      bus.busy           <= 1'b0;
      bus.Decrypt_Valid  <= 1'b0;
      bus.Checker_Finish <= 1'b0;
      bus.bad_index      <= '0;
    end else begin
      bus.Checker_Finish <= 1'b0;
      if (accept) begin
        state             <= SCAN;
        chk_en            <= 1'b0;
        fail              <= 1'b0;
        bus.rd_addr       <= '0;
        bus.busy          <= 1'b1;
        bus.Decrypt_Valid <= 1'b0;
        bus.bad_index     <= '0;
      end else begin
        case (state)
          SCAN: begin
            // data_idx/chk_en trail rd_addr by one cycle to line up with the RAM's read latency
            chk_en   <= 1'b1;
            data_idx <= bus.rd_addr;
            if (bus.rd_addr != LAST_ADDR) bus.rd_addr <= bus.rd_addr + 1'b1;
            if (chk_en) begin
              if (byte_bad && !fail) begin
                fail          <= 1'b1;
                bus.bad_index <= data_idx;
              end
              // on early abort the read still in flight is dropped with chk_en
              if ((data_idx == LAST_ADDR) || (EARLY_ABORT && byte_bad)) begin
                state              <= DONE;
                chk_en             <= 1'b0;
                bus.busy           <= 1'b0;
                bus.Checker_Finish <= 1'b1;
                bus.Decrypt_Valid  <= !(fail || byte_bad);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
